// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch-stage definitions: widths, reset PC, instruction size, FSM encodings.
package instr_fetch_unit_pkg;

  localparam int unsigned XLEN             = 32;
  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_0000;
  localparam int unsigned INSTR_BYTES      = 4;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_REQ  = 2'd1,
    FETCH_DROP = 2'd2
  } fetchState_e;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus: instruction-memory handshake, redirect input, and IR output handshake.
interface instr_fetch_unit_if
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned WIDTH = XLEN
);

  logic             imem_req;
  logic [WIDTH-1:0] imem_addr;
  logic             imem_ack;
  logic [WIDTH-1:0] imem_rdata;
  logic             redirect_valid;
  logic [WIDTH-1:0] redirect_pc;
  logic             ir_valid;
  logic [WIDTH-1:0] ir_out;
  logic [WIDTH-1:0] ir_pc;
  logic             ir_ready;

  // Fetch unit side
  modport master (
    output imem_req, imem_addr, ir_valid, ir_out, ir_pc,
    input  imem_ack, imem_rdata, redirect_valid, redirect_pc, ir_ready
  );

  // Memory/datapath/branch-unit side
  modport slave (
    input  imem_req, imem_addr, ir_valid, ir_out, ir_pc,
    output imem_ack, imem_rdata, redirect_valid, redirect_pc, ir_ready
  );

endinterface

// File: rtl/instr_fetch_unit_fetch_fifo.sv
// Prefetch FIFO: push/pop/flush with occupancy count and registered head storage.
module fetch_fifo #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned DEPTH  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [DATA_W-1:0]        pushData,
  input  logic                     pop,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic [DATA_W-1:0]        headData
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wrPtr;
  logic [PTR_W-1:0]  rdPtr;
  logic              popEn;

  // Popping an empty FIFO is ignored
  assign popEn = pop & (count != '0);

  // Storage, pointers (wrap naturally at power-of-2 depth) and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wrPtr] <= pushData;
        wrPtr      <= wrPtr + PTR_W'(1);
      end
      if (popEn) rdPtr <= rdPtr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(popEn);
    end
  end

  assign headData = mem[rdPtr];

  // The fetch FSM reserves a slot per outstanding request, so overflow is impossible
  always_comb begin
    assert (count <= CNT_W'(DEPTH));
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC register, single-outstanding imem request FSM, prefetch FIFO to the IR.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned     WIDTH      = XLEN,
  parameter logic [WIDTH-1:0] PC_RESET  = WIDTH'(PC_RESET_DEFAULT),
  parameter int unsigned     FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  instr_fetch_unit_if.master bus
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  fetchState_e       state;
  logic [WIDTH-1:0]  fetchPc;
  logic [WIDTH-1:0]  imemAddr;
  logic [WIDTH-1:0]  redirTarget;
  logic [WIDTH-1:0]  nextPc;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  countNext;
  logic              irValid;
  logic              push;
  logic              pop;
  logic              flush;
  logic              space;
  logic [2*WIDTH-1:0] headData;

  // Handshake qualifiers and the slot-reservation space check
  always_comb begin
    redirTarget = bus.redirect_pc & ~WIDTH'(3);
    nextPc      = fetchPc + WIDTH'(INSTR_BYTES);
    irValid     = (count != '0);
    flush       = bus.redirect_valid;
    pop         = irValid & bus.ir_ready & ~bus.redirect_valid;
    push        = (state == FETCH_REQ) & bus.imem_ack & ~bus.redirect_valid;
    countNext   = flush ? '0 : (count + CNT_W'(push) - CNT_W'(pop));
    space       = (countNext < CNT_W'(FIFO_DEPTH));
  end

  // Fetch FSM with PC and request address registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= FETCH_IDLE;
      fetchPc  <= PC_RESET;
      imemAddr <= PC_RESET;
    end else begin
      case (state)
        FETCH_IDLE: begin
          if (bus.redirect_valid) fetchPc <= redirTarget;
          if (space) begin
            state    <= FETCH_REQ;
            imemAddr <= bus.redirect_valid ? redirTarget : fetchPc;
          end
        end
        FETCH_REQ: begin
          if (bus.imem_ack) begin
            if (bus.redirect_valid) begin
              fetchPc  <= redirTarget;
              imemAddr <= redirTarget;
            end else begin
              fetchPc <= nextPc;
              if (space) imemAddr <= nextPc;
              else       state    <= FETCH_IDLE;
            end
          end else if (bus.redirect_valid) begin
            fetchPc <= redirTarget;
            state   <= FETCH_DROP;
          end
        end
        FETCH_DROP: begin
          // Stale request stays up until accepted; its data is thrown away
          if (bus.imem_ack) begin
            state    <= FETCH_REQ;
            imemAddr <= bus.redirect_valid ? redirTarget : fetchPc;
            if (bus.redirect_valid) fetchPc <= redirTarget;
          end else if (bus.redirect_valid) begin
            fetchPc <= redirTarget;
          end
        end
        default: state <= FETCH_IDLE;
      endcase
    end
  end

  fetch_fifo #(
    .DATA_W (2 * WIDTH),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (reset),
    .push     (push),
    .pushData ({bus.imem_rdata, imemAddr}),
    .pop      (pop),
    .flush    (flush),
    .count    (count),
    .headData (headData)
  );

  assign bus.imem_req  = (state != FETCH_IDLE);
  assign bus.imem_addr = imemAddr;
  assign bus.ir_valid  = irValid;
  assign bus.ir_out    = headData[2*WIDTH-1:WIDTH];
  assign bus.ir_pc     = headData[WIDTH-1:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: streaming, backpressure, redirects, wrap, reset abort.
module tb_instr_fetch_unit;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  instr_fetch_unit_if #(.WIDTH(32)) ifc ();

  instr_fetch_unit #(
    .WIDTH      (32),
    .PC_RESET   (32'h0),
    .FIFO_DEPTH (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  // Instruction memory contents: a simple address-derived pattern
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  assign ifc.imem_rdata = memWord(ifc.imem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and land on the following falling edge
  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    reset          = 1'b0;
    ifc.imem_ack       = 1'b1;
    ifc.redirect_valid = 1'b0;
    ifc.redirect_pc    = 32'h0;
    ifc.ir_ready       = 1'b1;

    // Reset state
    step();
    chk("rst_req",   32'(ifc.imem_req), 32'h0);
    chk("rst_addr",  ifc.imem_addr,     32'h0);
    chk("rst_valid", 32'(ifc.ir_valid), 32'h0);
    chk("rst_irout", ifc.ir_out,        32'h0);
    chk("rst_irpc",  ifc.ir_pc,         32'h0);

    // 1: streaming, one instruction per cycle
    reset = 1'b1;
    step();
    chk("t1_req",   32'(ifc.imem_req), 32'h1);
    chk("t1_addr0", ifc.imem_addr,     32'h0);
    chk("t1_val0",  32'(ifc.ir_valid), 32'h0);
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("t1_addr",  ifc.imem_addr,     32'(4 * k));
      chk("t1_valid", 32'(ifc.ir_valid), 32'h1);
      chk("t1_irpc",  ifc.ir_pc,         32'(4 * (k - 1)));
      chk("t1_irout", ifc.ir_out,        memWord(32'(4 * (k - 1))));
    end

    // 2: backpressure fills exactly two entries, then drains in order
    reset = 1'b0;
    ifc.ir_ready = 1'b0;
    step();
    reset = 1'b1;
    step();
    chk("t2_addr0", ifc.imem_addr, 32'h0);
    step();
    chk("t2_addr4", ifc.imem_addr, 32'h4);
    step();
    chk("t2_req_off", 32'(ifc.imem_req), 32'h0);
    chk("t2_valid",   32'(ifc.ir_valid), 32'h1);
    chk("t2_irpc0",   ifc.ir_pc,         32'h0);
    step();
    chk("t2_req_hold", 32'(ifc.imem_req), 32'h0);
    chk("t2_irpc0b",   ifc.ir_pc,         32'h0);
    ifc.ir_ready = 1'b1;
    step();
    chk("t2_req_on", 32'(ifc.imem_req), 32'h1);
    chk("t2_addr8",  ifc.imem_addr,     32'h8);
    chk("t2_irpc4",  ifc.ir_pc,         32'h4);
    step();
    chk("t2_irpc8",  ifc.ir_pc,         32'h8);
    chk("t2_irout8", ifc.ir_out,        memWord(32'h8));

    // 3: redirect while REQ at 0x8 without ack goes to DROP
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
    step();
    step();
    chk("t3_addr8", ifc.imem_addr, 32'h8);
    ifc.imem_ack       = 1'b0;
    ifc.redirect_valid = 1'b1;
    ifc.redirect_pc    = 32'h100;
    step();
    ifc.redirect_valid = 1'b0;
    chk("t3_drop_req",   32'(ifc.imem_req), 32'h1);
    chk("t3_drop_addr",  ifc.imem_addr,     32'h8);
    chk("t3_drop_valid", 32'(ifc.ir_valid), 32'h0);
    step();
    step();
    chk("t3_hold_addr", ifc.imem_addr, 32'h8);
    ifc.imem_ack = 1'b1;
    step();
    chk("t3_new_addr", ifc.imem_addr,     32'h100);
    chk("t3_discard",  32'(ifc.ir_valid), 32'h0);
    step();
    chk("t3_irpc",  ifc.ir_pc,  32'h100);
    chk("t3_irout", ifc.ir_out, memWord(32'h100));
    chk("t3_addr",  ifc.imem_addr, 32'h104);

    // 4: redirect coincident with ack and pop
    ifc.redirect_valid = 1'b1;
    ifc.redirect_pc    = 32'h40;
    step();
    ifc.redirect_valid = 1'b0;
    chk("t4_flush", 32'(ifc.ir_valid), 32'h0);
    chk("t4_addr",  ifc.imem_addr,     32'h40);
    step();
    chk("t4_irpc", ifc.ir_pc,     32'h40);
    chk("t4_next", ifc.imem_addr, 32'h44);

    // 5: misaligned target is forced aligned; PC wraps past the top
    ifc.redirect_valid = 1'b1;
    ifc.redirect_pc    = 32'h103;
    step();
    chk("t5_align", ifc.imem_addr, 32'h100);
    ifc.redirect_pc = 32'hFFFF_FFFC;
    step();
    ifc.redirect_valid = 1'b0;
    chk("t5_top", ifc.imem_addr, 32'hFFFF_FFFC);
    step();
    chk("t5_wrap",   ifc.imem_addr, 32'h0);
    chk("t5_irtop",  ifc.ir_pc,     32'hFFFF_FFFC);
    step();
    chk("t5_irwrap", ifc.ir_pc,     32'h0);

    // 6: asynchronous reset mid-REQ and mid-DROP
    chk("t6_pre_valid", 32'(ifc.ir_valid), 32'h1);
    #1;
    reset = 1'b0;
    #1;
    chk("t6_req_abort",   32'(ifc.imem_req), 32'h0);
    chk("t6_valid_abort", 32'(ifc.ir_valid), 32'h0);
    step();
    reset = 1'b1;
    step();
    chk("t6_restart", ifc.imem_addr,     32'h0);
    chk("t6_req",     32'(ifc.imem_req), 32'h1);
    ifc.imem_ack       = 1'b0;
    ifc.redirect_valid = 1'b1;
    ifc.redirect_pc    = 32'h200;
    step();
    ifc.redirect_valid = 1'b0;
    chk("t6_drop_req", 32'(ifc.imem_req), 32'h1);
    #1;
    reset = 1'b0;
    #1;
    chk("t6_drop_abort", 32'(ifc.imem_req), 32'h0);
    ifc.imem_ack = 1'b1;
    step();
    reset = 1'b1;
    step();
    chk("t6_restart2", ifc.imem_addr,     32'h0);
    chk("t6_req2",     32'(ifc.imem_req), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
